dice_pred_rf_seq: RTL

Thread-sweep sequencer for the 16-port, 1-bit predicate register file and its per-port latency pipes.
- On a CTA launch it issues one thread ID per cycle as the RF read address.
- It delays each issued TID by the CGRA pipeline latency and drives the matching RF write-back address and enables.
- It also runs a zero-initialisation sweep over all NUM_TID entries, because the RF storage has no reset.
- Sits between the CTA dispatcher and the predicate RF control block.

---
 rtl/dice_pred_rf_seq_if.sv | 39 +++
 rtl/dice_pred_rf_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dice_pred_rf_seq_if.sv
// Control bundle between the CTA dispatcher (master) and the predicate RF
// thread-sweep sequencer (slave).
interface dice_pred_rf_seq_if #(
    parameter int NUM_PORTS     = 16,
    parameter int NUM_TID       = 512,
    parameter int MAX_CGRA_LAT  = 32,
    parameter int RF_ADDR_WIDTH = $clog2(NUM_TID),
    parameter int LAT_W         = $clog2(MAX_CGRA_LAT + 1)
);
    // launch / control
    logic                     start;
    logic [RF_ADDR_WIDTH-1:0] tid_base;
    logic [RF_ADDR_WIDTH:0]   tid_count;
    logic [LAT_W-1:0]         cgra_lat;
    logic [NUM_PORTS-1:0]     rd_mask;
    logic [NUM_PORTS-1:0]     wr_mask;
    logic                     stall;
    logic                     init_req;
    // status / RF control
    logic                     busy;
    logic                     done;
    logic                     init_done;
    logic                     clr;
    logic [NUM_PORTS-1:0]     rd_en;
    logic [RF_ADDR_WIDTH-1:0] rd_tid;
    logic [NUM_PORTS-1:0]     wr_en;
    logic [RF_ADDR_WIDTH-1:0] wr_tid;
    logic                     init_active;

    modport master (
        output start, tid_base, tid_count, cgra_lat, rd_mask, wr_mask, stall, init_req,
        input  busy, done, init_done, clr, rd_en, rd_tid, wr_en, wr_tid, init_active
    );

    modport slave (
        input  start, tid_base, tid_count, cgra_lat, rd_mask, wr_mask, stall, init_req,
        output busy, done, init_done, clr, rd_en, rd_tid, wr_en, wr_tid, init_active
    );
endinterface

// File: rtl/dice_pred_rf_seq.sv
// Predicate RF thread-sweep sequencer: issues one TID per cycle as the RF read
// address, replays each TID through a latency delay line as the write-back
// address, and runs a zero-init sweep over the whole RF on request.
// Every output is a register; an action decided at a clock edge (using the
// stall value sampled at that edge) becomes visible in the following cycle.
module dice_pred_rf_seq #(
    parameter int NUM_PORTS     = 16,
    parameter int NUM_TID       = 512,
    parameter int MAX_CGRA_LAT  = 32,
    parameter int RF_ADDR_WIDTH = $clog2(NUM_TID),
    parameter int LAT_W         = $clog2(MAX_CGRA_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    dice_pred_rf_seq_if.slave bus
);
    localparam int DL_IW = (MAX_CGRA_LAT > 1) ? $clog2(MAX_CGRA_LAT) : 1;
    localparam int CNT_W = RF_ADDR_WIDTH + 1;
    localparam logic [RF_ADDR_WIDTH-1:0] LAST_TID = RF_ADDR_WIDTH'(NUM_TID - 1);
    localparam logic [LAT_W-1:0]         MAX_LAT  = LAT_W'(MAX_CGRA_LAT);

    typedef enum logic [2:0] {IDLE, INIT, ISSUE, DRAIN, FIN} state_t;

    typedef struct packed {
        logic                     vld;
        logic [RF_ADDR_WIDTH-1:0] tid;
    } dl_ent_t;

    state_t state, state_n;

    // launch context, captured on an accepted start
    logic [CNT_W-1:0]         cnt;
    logic [NUM_PORTS-1:0]     rmask, wmask;
    logic [DL_IW-1:0]         lat_m1;
    // sweep / issue bookkeeping
    logic [RF_ADDR_WIDTH-1:0] a;
    logic [RF_ADDR_WIDTH-1:0] ptr;
    logic [CNT_W-1:0]         issued;
    logic [LAT_W-1:0]         outstanding;
    logic [LAT_W-1:0]         lat_eff;
    dl_ent_t                  dl [MAX_CGRA_LAT];
    dl_ent_t                  dl_out;

    logic acc_init, acc_start, push, adv, emerge;

    // registered outputs
    logic                     busy_q, done_q, init_done_q, clr_q, init_active_q;
    logic [NUM_PORTS-1:0]     rd_en_q, wr_en_q;
    logic [RF_ADDR_WIDTH-1:0] rd_tid_q, wr_tid_q;

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.init_done   = init_done_q;
    assign bus.clr         = clr_q;
    assign bus.init_active = init_active_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_tid      = rd_tid_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_tid      = wr_tid_q;

    // Tap of the delay line for the launch latency; the entry reaching it on an
    // advancing edge is the one being written back.
    assign dl_out = dl[lat_m1];
    assign emerge = adv & dl_out.vld;

    // Effective latency: 0 behaves as 1, anything beyond the line length saturates.
    always_comb begin
        if (bus.cgra_lat == '0)          lat_eff = LAT_W'(1);
        else if (bus.cgra_lat > MAX_LAT) lat_eff = MAX_LAT;
        else                             lat_eff = bus.cgra_lat;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state and per-edge actions (issue, delay-line advance).
    // The done cycle is spent in IDLE, so done_q blocks a new launch there
    // while busy is still reported.
    always_comb begin
        state_n   = state;
        acc_init  = 1'b0;
        acc_start = 1'b0;
        push      = 1'b0;
        adv       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!done_q) begin
                    if (bus.init_req) begin
                        acc_init = 1'b1;
                        state_n  = INIT;
                    end else if (bus.start) begin
                        acc_start = 1'b1;
                        state_n   = (bus.tid_count == '0) ? FIN : ISSUE;
                    end
                end
            end
            INIT: begin
                if (a == LAST_TID) state_n = IDLE;
            end
            ISSUE: begin
                if (!bus.stall) begin
                    push = 1'b1;
                    adv  = 1'b1;
                    if (issued + CNT_W'(1) == cnt) state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding == '0) begin
                    state_n = FIN;
                end else if (!bus.stall) begin
                    adv = 1'b1;
                    if (dl_out.vld && outstanding == LAT_W'(1)) state_n = FIN;
                end
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Launch context, sweep address, issue pointer and outstanding count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            rmask       <= '0;
            wmask       <= '0;
            lat_m1      <= '0;
            a           <= '0;
            ptr         <= '0;
            issued      <= '0;
            outstanding <= '0;
        end else begin
            if (acc_init)            a <= '0;
            else if (state == INIT)  a <= a + RF_ADDR_WIDTH'(1);

            if (acc_start) begin
                cnt    <= bus.tid_count;
                rmask  <= bus.rd_mask;
                wmask  <= bus.wr_mask;
                lat_m1 <= DL_IW'(lat_eff - LAT_W'(1));
                ptr    <= bus.tid_base;
                issued <= '0;
            end else if (push) begin
                issued <= issued + CNT_W'(1);
                ptr    <= (ptr == LAST_TID) ? '0 : ptr + RF_ADDR_WIDTH'(1);
            end

            if (acc_start)             outstanding <= '0;
            else if (push && !emerge)  outstanding <= outstanding + LAT_W'(1);
            else if (emerge && !push)  outstanding <= outstanding - LAT_W'(1);
        end
    end

    // Delay line of {valid, tid}; cleared at launch, shifts only on non-stall edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_CGRA_LAT; i++) dl[i] <= '0;
        end else if (acc_start) begin
            for (int i = 0; i < MAX_CGRA_LAT; i++) dl[i] <= '0;
        end else if (adv) begin
            dl[0] <= '{vld: push, tid: ptr};
            for (int i = 1; i < MAX_CGRA_LAT; i++) dl[i] <= dl[i-1];
        end
    end

    // Output registers; addresses hold whenever their enable is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            init_done_q   <= 1'b0;
            clr_q         <= 1'b0;
            init_active_q <= 1'b0;
            rd_en_q       <= '0;
            rd_tid_q      <= '0;
            wr_en_q       <= '0;
            wr_tid_q      <= '0;
        end else begin
            clr_q         <= acc_init | (acc_start & (bus.tid_count != '0));
            done_q        <= (state == FIN);
            init_done_q   <= (state == INIT) && (a == LAST_TID);
            busy_q        <= (state_n != IDLE) || (state == FIN);
            init_active_q <= (state_n == INIT);

            rd_en_q <= push ? rmask : '0;
            if (push && rmask != '0) rd_tid_q <= ptr;

            if (state_n == INIT) begin
                wr_en_q  <= '1;
                wr_tid_q <= acc_init ? '0 : a + RF_ADDR_WIDTH'(1);
            end else if (emerge) begin
                wr_en_q <= wmask;
                if (wmask != '0) wr_tid_q <= dl_out.tid;
            end else begin
                wr_en_q <= '0;
            end
        end
    end
endmodule
